karatsuba_sched: RTL and testbench



---
 rtl/karatsuba_sched.sv | 195 +++++++++++++++++++
 tb/tb_karatsuba_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_sched.sv
// karatsuba_sched: N x N carry-less product from three shared half-width sub-multiplies,
// recombined two-way Karatsuba style. Optional sticky `overrun` output under KSCHED_OVERRUN_EN.
module karatsuba_sched #(
    parameter int N       = 409,
    parameter int MUL_LAT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N-1:0]           a,
    input  logic [N-1:0]           b,
    output logic                   busy,
    output logic                   done,
    output logic [2*N-1:0]         c,
    output logic [N-N/2-1:0]       sub_a,
    output logic [N-N/2-1:0]       sub_b,
    output logic                   sub_vld,
    input  logic [2*(N-N/2)-2:0]   sub_c
`ifdef KSCHED_OVERRUN_EN
    ,
    output logic                   overrun
`endif
);

    localparam int H  = N / 2;
    localparam int W  = N - H;
    localparam int PW = 2 * W - 1;
    localparam int CW = 2 * N;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMBINE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [W-1:0]    ahi_q, ahi_d, bhi_q, bhi_d;
    logic [H-1:0]    alo_q, alo_d, blo_q, blo_d;
    logic [PW-1:0]   p_hi_q, p_hi_d, p_lo_q, p_lo_d, p_mid_q, p_mid_d;
    logic [CW-1:0]   c_q, c_d;

    // Tag = {valid, op index}; travels alongside each op through the sub-multiplier.
    logic [2:0]      tag_q [MUL_LAT];
    logic [2:0]      tag_in;
    logic [2:0]      cap;
    logic            cap_mid;
    logic            accept;
    logic [W-1:0]    alo_ext, blo_ext;

    assign alo_ext = W'(alo_q);
    assign blo_ext = W'(blo_q);
    assign accept  = (state_q == S_IDLE) && start;
    assign cap     = tag_q[MUL_LAT-1];
    assign cap_mid = cap[2] && (cap[1:0] == 2'd2);

    always_comb begin
        sub_vld = 1'b0;
        sub_a   = '0;
        sub_b   = '0;
        tag_in  = '0;
        if (state_q == S_ISSUE) begin
            sub_vld = 1'b1;
            tag_in  = {1'b1, idx_q};
            case (idx_q)
                2'd0: begin
                    sub_a = ahi_q;
                    sub_b = bhi_q;
                end
                2'd1: begin
                    sub_a = alo_ext;
                    sub_b = blo_ext;
                end
                default: begin
                    sub_a = ahi_q ^ alo_ext;
                    sub_b = bhi_q ^ blo_ext;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < MUL_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    always_comb begin
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        p_mid_d = p_mid_q;
        if (cap[2]) begin
            case (cap[1:0])
                2'd0:    p_hi_d  = sub_c;
                2'd1:    p_lo_d  = sub_c;
                default: p_mid_d = sub_c;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ahi_d   = ahi_q;
        alo_d   = alo_q;
        bhi_d   = bhi_q;
        blo_d   = blo_q;
        c_d     = c_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ahi_d   = a[N-1:H];
                    alo_d   = a[H-1:0];
                    bhi_d   = b[N-1:H];
                    blo_d   = b[H-1:0];
                    idx_d   = 2'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd2) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cap_mid) state_d = S_COMBINE;
            end
            S_COMBINE: begin
                // The middle product still contains hi and lo; XOR cancels them out.
                c_d = (CW'(p_hi_q) << (2 * H))
                    ^ (CW'(p_mid_q ^ p_hi_q ^ p_lo_q) << H)
                    ^ CW'(p_lo_q);
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ahi_q   <= '0;
            alo_q   <= '0;
            bhi_q   <= '0;
            blo_q   <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            p_mid_q <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ahi_q   <= ahi_d;
            alo_q   <= alo_d;
            bhi_q   <= bhi_d;
            blo_q   <= blo_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            p_mid_q <= p_mid_d;
            c_q     <= c_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign c    = c_q;

`ifdef KSCHED_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (accept) overrun_d = 1'b0;
        else if (start && busy) overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) overrun_q <= 1'b0;
        else     overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_karatsuba_sched.sv
// Bench for karatsuba_sched: behavioural fixed-latency sub-multiplier plus a direct
// shift-and-XOR reference product. Overrun checks compile in with KSCHED_OVERRUN_EN.
`timescale 1ns/1ps
module tb_karatsuba_sched;

    localparam int N       = 409;
    localparam int MUL_LAT = 3;
    localparam int H       = N / 2;
    localparam int W       = N - H;
    localparam int PW      = 2 * W - 1;
    localparam int CW      = 2 * N;
    localparam int LAT     = 4 + MUL_LAT;   // accepting edge to done-visible, in edges
    localparam int PERIOD  = 6 + MUL_LAT;   // done-to-done spacing with start held high
    localparam int NPAIRS  = 1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  a, b;
    logic          busy, done, sub_vld;
    logic [CW-1:0] c;
    logic [W-1:0]  sub_a, sub_b;
    logic [PW-1:0] sub_c;
`ifdef KSCHED_OVERRUN_EN
    logic          overrun;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    karatsuba_sched #(.N(N), .MUL_LAT(MUL_LAT)) dut (
`ifdef KSCHED_OVERRUN_EN
        .overrun (overrun),
`endif
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .c       (c),
        .sub_a   (sub_a),
        .sub_b   (sub_b),
        .sub_vld (sub_vld),
        .sub_c   (sub_c)
    );

    function automatic logic [PW-1:0] clmul_w(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) if (y[i]) r ^= PW'(x) << i;
        return r;
    endfunction

    function automatic logic [CW-1:0] clmul_n(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) if (y[i]) r ^= CW'(x) << i;
        return r;
    endfunction

    function automatic logic [N-1:0] rand_n();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < (N + 31) / 32; i++) r = (r << 32) | N'($urandom);
        return r;
    endfunction

    // Fixed-latency sub-multiplier: result for the op sampled at an edge shows
    // up MUL_LAT cycles after that op was presented.
    logic [PW-1:0] pipe [MUL_LAT];
    always @(posedge clk) begin
        pipe[0] <= clmul_w(sub_a, sub_b);
        for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign sub_c = pipe[MUL_LAT-1];

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; runs one full transaction.
    task automatic run_op(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic [CW-1:0] exp);
        int vld_cnt, lat, nz;
        vld_cnt = 0;
        lat     = -1;
        nz      = 0;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (sub_vld) vld_cnt++;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (sub_vld) vld_cnt++;
            else if (sub_a != '0 || sub_b != '0) nz++;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_lat"}, CW'(lat), CW'(LAT));
        chk({tag, "_vld"}, CW'(vld_cnt), CW'(3));
        chk({tag, "_idle_ops"}, CW'(nz), CW'(0));
        chk({tag, "_c"}, c, exp);
        @(negedge clk);
        chk({tag, "_pulse"}, CW'(done), CW'(0));
        chk({tag, "_hold"}, c, exp);
        $display("txn %s lat=%0d c_low=%0h", tag, lat, c[63:0]);
    endtask

    initial begin
        logic [N-1:0]  x, y;
        logic [CW-1:0] exp_q [$];
        int            dcnt, lat, last_done;
        bit            found;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", CW'(busy), CW'(0));
        chk("rst_done", CW'(done), CW'(0));
        chk("rst_vld", CW'(sub_vld), CW'(0));
        chk("rst_ops", CW'({sub_a, sub_b}), CW'(0));
        chk("rst_c", c, CW'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", CW'(busy), CW'(0));

        run_op("small", N'(3), N'(3), CW'(5));
        run_op("top", N'(1) << (N - 1), N'(1) << (N - 1), CW'(1) << (2 * N - 2));
        x = rand_n();
        run_op("zero", N'(0), x, CW'(0));
        run_op("cross", (N'(1) << H) | N'(1), (N'(1) << H) | N'(1), (CW'(1) << (2 * H)) | CW'(1));
        for (int i = 0; i < 4; i++) begin
            x = rand_n();
            y = rand_n();
            run_op("rand", x, y, clmul_n(x, y));
        end
        run_op("small2", N'(3), N'(3), CW'(5));

        // Reset in the middle of an operation.
        a = rand_n();
        b = rand_n();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", CW'(busy), CW'(0));
        chk("mid_rst_c", c, CW'(0));
        chk("mid_rst_done", CW'(done), CW'(0));
        chk("mid_rst_vld", CW'(sub_vld), CW'(0));
        rst = 1'b0;
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("mid_rst_nodone", CW'(dcnt), CW'(0));
        run_op("after_rst", N'(3), N'(5), CW'(15));

        // Start pulsed while busy: ignored, not queued, and flagged when enabled.
`ifdef KSCHED_OVERRUN_EN
        chk("ovr_pre", CW'(overrun), CW'(0));
`endif
        x = rand_n();
        y = rand_n();
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        @(negedge clk);
        lat++;
        a = rand_n();
        b = rand_n();
        start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0;
`ifdef KSCHED_OVERRUN_EN
        chk("ovr_set", CW'(overrun), CW'(1));
`endif
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        chk("ign_found", CW'(found), CW'(1));
        chk("ign_lat", CW'(lat), CW'(LAT));
        chk("ign_c", c, clmul_n(x, y));
        dcnt = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("ign_noqueue", CW'(dcnt), CW'(0));
`ifdef KSCHED_OVERRUN_EN
        chk("ovr_sticky", CW'(overrun), CW'(1));
`endif
        run_op("post_ovr", N'(6), N'(7), CW'(18));
`ifdef KSCHED_OVERRUN_EN
        chk("ovr_clear", CW'(overrun), CW'(0));
`endif

        // Back-to-back with start held high; new operands presented in each done cycle.
        x = rand_n();
        y = rand_n();
        a = x;
        b = y;
        exp_q.push_back(clmul_n(x, y));
        start = 1'b1;
        last_done = 0;
        for (int n = 0; n < NPAIRS; n++) begin
            found = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (done) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("b2b_found", CW'(found), CW'(1));
            if (!found) break;
            chk("b2b_c", c, exp_q.pop_front());
            if (n > 0) chk("b2b_gap", CW'(cyc - last_done), CW'(PERIOD));
            last_done = cyc;
            $display("txn b2b %0d c_low=%0h", n, c[63:0]);
            if (n < NPAIRS - 1) begin
                x = (n % 97 == 5)  ? '1 : rand_n();
                y = (n % 101 == 7) ? '1 : rand_n();
                a = x;
                b = y;
                exp_q.push_back(clmul_n(x, y));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("end_idle", CW'(busy), CW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
